// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: Tuse/Tnew data hazards,
// mult/div busy sequencing, pipeline stall controls and a stall-cycle counter.
//
// state | meaning
// IDLE  | mult/div unit free
// BUSY  | mult/div in progress, md_cnt busy cycles remain
module pipe_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_use_rs,
  input  logic             D_use_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_A3,
  input  logic             E_RegWrite,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_A3,
  input  logic             M_RegWrite,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_clr,
  output logic             md_busy,
  output logic [3:0]       md_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  md_state_t  state, state_nxt;
  logic [3:0] md_cnt_nxt;
  logic       stall_rs, stall_rt, stall_md, stall;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // A start seen while BUSY is ignored: the stall makes it unreachable.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          state_nxt  = BUSY;
          md_cnt_nxt = E_md_div ? DIV_LD : MULT_LD;
        end
      end
      BUSY: begin
        if (md_cnt <= 4'd1) begin
          state_nxt  = IDLE;
          md_cnt_nxt = '0;
        end else begin
          md_cnt_nxt = md_cnt - 4'd1;
        end
      end
    endcase
  end

  // Tnew=0 never satisfies Tuse<Tnew, so forwarded results never stall.
  always_comb begin
    md_busy  = (state == BUSY);
    stall_rs = D_use_rs && (D_rs != 5'd0) &&
               ((E_RegWrite && (E_A3 == D_rs) && (D_Tuse_rs < E_Tnew)) ||
                (M_RegWrite && (M_A3 == D_rs) && (D_Tuse_rs < M_Tnew)));
    stall_rt = D_use_rt && (D_rt != 5'd0) &&
               ((E_RegWrite && (E_A3 == D_rt) && (D_Tuse_rt < E_Tnew)) ||
                (M_RegWrite && (M_A3 == D_rt) && (D_Tuse_rt < M_Tnew)));
    stall_md = D_is_md && (E_md_start || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
    PC_en    = !stall;
    IFID_en  = !stall;
    IDEX_clr = stall;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
